mini_src_control_unit: RTL and testbench

Hardwired control unit for the Mini SRC datapath. It replaces bench-driven strobes with an FSM that fetches an instruction (T0–T2), decodes the IR, and sequences the execute steps (T3–T6) for R-format ALU, unary, multiply/divide, nop and halt instructions. It sits beside `DataPath`, reads the IR contents and drives every register `out`/`en` strobe, the memory-read strobe and `alu_control`.

---
 rtl/mini_src_pkg.sv | 56 +++++
 rtl/reg_select_decoder.sv | 17 +
 rtl/mini_src_control_unit.sv | 165 ++++++++++++++++
 tb/tb_mini_src_control_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared types and constants for the Mini SRC hardwired control unit:
// FSM states, opcode map, IR field positions and opcode classification.
package mini_src_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_HALT
    } op_class_t;

    localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
    localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
    localparam logic [4:0] OP_SHR       = 5'b00101;
    localparam logic [4:0] OP_MUL       = 5'b01111;
    localparam logic [4:0] OP_DIV       = 5'b10000;
    localparam logic [4:0] OP_NEG       = 5'b10001;
    localparam logic [4:0] OP_NOT       = 5'b10010;
    localparam logic [4:0] OP_NOP       = 5'b11010;
    localparam logic [4:0] OP_HALT      = 5'b11011;

    localparam logic [4:0] ALU_INC  = 5'b11111;
    localparam logic [4:0] ALU_NONE = 5'b00000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RA_MSB     = 26;
    localparam int RA_LSB     = 23;
    localparam int RB_MSB     = 22;
    localparam int RB_LSB     = 19;
    localparam int RC_MSB     = 18;
    localparam int RC_LSB     = 15;

    // Any opcode outside the known classes runs as a nop.
    function automatic op_class_t classify(input logic [4:0] op);
        if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) return CLS_ALU;
        if (op == OP_MUL || op == OP_DIV)           return CLS_MULDIV;
        if (op == OP_NEG || op == OP_NOT)           return CLS_UNARY;
        if (op == OP_HALT)                          return CLS_HALT;
        return CLS_NOP;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a 4-bit register field plus an enable into a one-hot register
// strobe vector (bit n selects Rn).
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          field,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (field == 4'(i));
        end
    end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Mini SRC control unit: fetch (T0-T2), decode, and execute
// sequencing (T3-T6); all strobes are a combinational decode of state and IR.
module mini_src_control_unit
    import mini_src_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [DATA_W-1:0]   ir,
    output logic [4:0]          alu_control,
    output logic [NUM_REGS-1:0] r_out,
    output logic [NUM_REGS-1:0] r_en,
    output logic                pc_out,
    output logic                pc_en,
    output logic                mar_en,
    output logic                mdr_out,
    output logic                mdr_en,
    output logic                read,
    output logic                ir_en,
    output logic                y_en,
    output logic                zlo_en,
    output logic                zhi_en,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                lo_en,
    output logic                hi_en,
    output logic                instr_done,
    output logic                halted
);

    state_t    state, next_state;
    op_class_t op_class;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic [3:0] r_out_field, r_en_field;
    logic       r_out_sel, r_en_sel;
    logic       unused_ir_bits;

    assign opcode   = ir[OPCODE_MSB:OPCODE_LSB];
    assign ra       = ir[RA_MSB:RA_LSB];
    assign rb       = ir[RB_MSB:RB_LSB];
    assign rc       = ir[RC_MSB:RC_LSB];
    assign op_class = classify(opcode);
    assign unused_ir_bits = ^ir[RC_LSB-1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; clr is synchronous and wins over everything.
    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= next_state;
    end

    // NOTE: every output and next_state gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        next_state  = state;
        alu_control = ALU_NONE;
        r_out_field = '0;
        r_out_sel   = 1'b0;
        r_en_field  = '0;
        r_en_sel    = 1'b0;
        pc_out      = 1'b0;
        pc_en       = 1'b0;
        mar_en      = 1'b0;
        mdr_out     = 1'b0;
        mdr_en      = 1'b0;
        read        = 1'b0;
        ir_en       = 1'b0;
        y_en        = 1'b0;
        zlo_en      = 1'b0;
        zhi_en      = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        lo_en       = 1'b0;
        hi_en       = 1'b0;
        instr_done  = 1'b0;
        halted      = 1'b0;

        unique case (state)
            ST_IDLE: next_state = run ? ST_T0 : ST_IDLE;
            ST_T0: begin
                pc_out      = 1'b1;
                mar_en      = 1'b1;
                zlo_en      = 1'b1;
                alu_control = ALU_INC;
                next_state  = ST_T1;
            end
            ST_T1: begin
                zlo_out    = 1'b1;
                pc_en      = 1'b1;
                read       = 1'b1;
                mdr_en     = 1'b1;
                next_state = ST_T2;
            end
            ST_T2: begin
                mdr_out = 1'b1;
                ir_en   = 1'b1;
                // Decided from the opcode visible on ir during T2.
                unique case (op_class)
                    CLS_HALT: next_state = ST_HALT;
                    CLS_NOP:  instr_done = 1'b1;
                    default:  next_state = ST_T3;
                endcase
            end
            ST_T3: begin
                next_state = ST_T4;
                if (op_class == CLS_ALU) begin
                    r_out_field = rb;
                    r_out_sel   = 1'b1;
                    y_en        = 1'b1;
                end else if (op_class == CLS_MULDIV) begin
                    r_out_field = ra;
                    r_out_sel   = 1'b1;
                    y_en        = 1'b1;
                end
            end
            ST_T4: begin
                next_state  = ST_T5;
                alu_control = opcode;
                zlo_en      = 1'b1;
                zhi_en      = (op_class == CLS_MULDIV);
                r_out_field = (op_class == CLS_ALU) ? rc : rb;
                r_out_sel   = 1'b1;
            end
            ST_T5: begin
                zlo_out = 1'b1;
                if (op_class == CLS_MULDIV) begin
                    lo_en      = 1'b1;
                    next_state = ST_T6;
                end else begin
                    r_en_field = ra;
                    r_en_sel   = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_T6: begin
                zhi_out    = 1'b1;
                hi_en      = 1'b1;
                instr_done = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: next_state = ST_IDLE;
        endcase

        // run is sampled only at instruction boundaries.
        if (instr_done) next_state = run ? ST_T0 : ST_IDLE;
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_r_out_dec (
        .field  (r_out_field),
        .en     (r_out_sel),
        .onehot (r_out)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_r_en_dec (
        .field  (r_en_field),
        .en     (r_en_sel),
        .onehot (r_en)
    );

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed, table-driven bench for mini_src_control_unit: one vector per
// clock cycle, plus hand-written halt and clear-mid-instruction sequences.
module tb_mini_src_control_unit;

    typedef struct packed {
        logic [4:0]  alu;
        logic [15:0] rout;
        logic [15:0] ren;
        logic [15:0] strb;
    } outs_t;

    typedef struct {
        logic        clr;
        logic        run;
        logic [31:0] ir;
        outs_t       exp;
    } vec_t;

    localparam logic [15:0] PC_OUT  = 16'h0001;
    localparam logic [15:0] PC_EN   = 16'h0002;
    localparam logic [15:0] MAR_EN  = 16'h0004;
    localparam logic [15:0] MDR_OUT = 16'h0008;
    localparam logic [15:0] MDR_EN  = 16'h0010;
    localparam logic [15:0] READ    = 16'h0020;
    localparam logic [15:0] IR_EN   = 16'h0040;
    localparam logic [15:0] Y_EN    = 16'h0080;
    localparam logic [15:0] ZLO_EN  = 16'h0100;
    localparam logic [15:0] ZHI_EN  = 16'h0200;
    localparam logic [15:0] ZLO_OUT = 16'h0400;
    localparam logic [15:0] ZHI_OUT = 16'h0800;
    localparam logic [15:0] LO_EN   = 16'h1000;
    localparam logic [15:0] HI_EN   = 16'h2000;
    localparam logic [15:0] DONE    = 16'h4000;
    localparam logic [15:0] HALTED  = 16'h8000;

    localparam logic [31:0] IR_SHR  = 32'h2891_8000; // Ra=1 Rb=2 Rc=3
    localparam logic [31:0] IR_MUL  = 32'h7B10_0000; // Ra=6 Rb=2
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_UNK  = 32'hF800_0000; // opcode 11111
    localparam logic [31:0] IR_NOT  = 32'h91A8_0000; // Ra=3 Rb=5
    localparam logic [31:0] IR_ADD7 = 32'h1BBB_8000; // Ra=Rb=Rc=7
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    logic        clk = 1'b0;
    logic        clr, run;
    logic [31:0] ir;
    logic [4:0]  alu_control;
    logic [15:0] r_out, r_en;
    logic pc_out, pc_en, mar_en, mdr_out, mdr_en, read, ir_en, y_en;
    logic zlo_en, zhi_en, zlo_out, zhi_out, lo_en, hi_en, instr_done, halted;

    int checks   = 0;
    int failures = 0;

    mini_src_control_unit #(.NUM_REGS(16), .DATA_W(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .run         (run),
        .ir          (ir),
        .alu_control (alu_control),
        .r_out       (r_out),
        .r_en        (r_en),
        .pc_out      (pc_out),
        .pc_en       (pc_en),
        .mar_en      (mar_en),
        .mdr_out     (mdr_out),
        .mdr_en      (mdr_en),
        .read        (read),
        .ir_en       (ir_en),
        .y_en        (y_en),
        .zlo_en      (zlo_en),
        .zhi_en      (zhi_en),
        .zlo_out     (zlo_out),
        .zhi_out     (zhi_out),
        .lo_en       (lo_en),
        .hi_en       (hi_en),
        .instr_done  (instr_done),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic outs_t o(input logic [4:0] alu, input logic [15:0] rout,
                                input logic [15:0] ren, input logic [15:0] strb);
        return '{alu: alu, rout: rout, ren: ren, strb: strb};
    endfunction

    function automatic vec_t v(input logic c, input logic r, input logic [31:0] i,
                               input outs_t e);
        return '{clr: c, run: r, ir: i, exp: e};
    endfunction

    function automatic outs_t sample();
        return '{alu: alu_control, rout: r_out, ren: r_en,
                 strb: {halted, instr_done, hi_en, lo_en, zhi_out, zlo_out,
                        zhi_en, zlo_en, y_en, ir_en, read, mdr_en, mdr_out,
                        mar_en, pc_en, pc_out}};
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got alu=%h r_out=%h r_en=%h strb=%h, expected alu=%h r_out=%h r_en=%h strb=%h",
                     name, got.alu, got.rout, got.ren, got.strb,
                     exp.alu, exp.rout, exp.ren, exp.strb);
        end
    endtask

    // Inputs are applied just after a rising edge; outputs are checked on the
    // falling edge; the inputs then take effect at the next rising edge.
    task automatic cycle(input string name, input logic c, input logic r,
                         input logic [31:0] i, input outs_t e);
        clr = c;
        run = r;
        ir  = i;
        @(negedge clk);
        check(name, sample(), e);
        @(posedge clk);
        #1;
    endtask

    outs_t z, f0, f1, f2;
    vec_t  tbl[$];

    initial begin
        z  = o(5'h00, 16'h0, 16'h0, 16'h0);
        f0 = o(5'h1F, 16'h0, 16'h0, PC_OUT | MAR_EN | ZLO_EN);
        f1 = o(5'h00, 16'h0, 16'h0, ZLO_OUT | PC_EN | READ | MDR_EN);
        f2 = o(5'h00, 16'h0, 16'h0, MDR_OUT | IR_EN);

        // Idle after reset, then shr.
        tbl.push_back(v(0, 0, IR_SHR, z));
        tbl.push_back(v(0, 0, IR_SHR, z));
        tbl.push_back(v(0, 1, IR_SHR, z));
        tbl.push_back(v(0, 1, IR_SHR, f0));
        tbl.push_back(v(0, 1, IR_SHR, f1));
        tbl.push_back(v(0, 1, IR_SHR, f2));
        tbl.push_back(v(0, 1, IR_SHR, o(5'h00, 16'h0004, 16'h0, Y_EN)));
        tbl.push_back(v(0, 1, IR_SHR, o(5'h05, 16'h0008, 16'h0, ZLO_EN)));
        tbl.push_back(v(0, 1, IR_SHR, o(5'h00, 16'h0, 16'h0002, ZLO_OUT | DONE)));
        // mul, back to back.
        tbl.push_back(v(0, 1, IR_MUL, f0));
        tbl.push_back(v(0, 1, IR_MUL, f1));
        tbl.push_back(v(0, 1, IR_MUL, f2));
        tbl.push_back(v(0, 1, IR_MUL, o(5'h00, 16'h0040, 16'h0, Y_EN)));
        tbl.push_back(v(0, 1, IR_MUL, o(5'h0F, 16'h0004, 16'h0, ZLO_EN | ZHI_EN)));
        tbl.push_back(v(0, 1, IR_MUL, o(5'h00, 16'h0, 16'h0, ZLO_OUT | LO_EN)));
        tbl.push_back(v(0, 1, IR_MUL, o(5'h00, 16'h0, 16'h0, ZHI_OUT | HI_EN | DONE)));
        // nop then unknown opcode: three cycles each, back to back.
        tbl.push_back(v(0, 1, IR_NOP, f0));
        tbl.push_back(v(0, 1, IR_NOP, f1));
        tbl.push_back(v(0, 1, IR_NOP, o(5'h00, 16'h0, 16'h0, MDR_OUT | IR_EN | DONE)));
        tbl.push_back(v(0, 1, IR_UNK, f0));
        tbl.push_back(v(0, 1, IR_UNK, f1));
        tbl.push_back(v(0, 1, IR_UNK, o(5'h00, 16'h0, 16'h0, MDR_OUT | IR_EN | DONE)));
        // not, ending with run low so the FSM parks in IDLE.
        tbl.push_back(v(0, 1, IR_NOT, f0));
        tbl.push_back(v(0, 1, IR_NOT, f1));
        tbl.push_back(v(0, 1, IR_NOT, f2));
        tbl.push_back(v(0, 1, IR_NOT, z));
        tbl.push_back(v(0, 1, IR_NOT, o(5'h12, 16'h0020, 16'h0, ZLO_EN)));
        tbl.push_back(v(0, 0, IR_NOT, o(5'h00, 16'h0, 16'h0008, ZLO_OUT | DONE)));
        tbl.push_back(v(0, 0, IR_NOT, z));
        // add with Ra=Rb=Rc; run drops during T4 and the instruction completes.
        tbl.push_back(v(0, 1, IR_ADD7, z));
        tbl.push_back(v(0, 1, IR_ADD7, f0));
        tbl.push_back(v(0, 1, IR_ADD7, f1));
        tbl.push_back(v(0, 1, IR_ADD7, f2));
        tbl.push_back(v(0, 1, IR_ADD7, o(5'h00, 16'h0080, 16'h0, Y_EN)));
        tbl.push_back(v(0, 0, IR_ADD7, o(5'h03, 16'h0080, 16'h0, ZLO_EN)));
        tbl.push_back(v(0, 0, IR_ADD7, o(5'h00, 16'h0, 16'h0080, ZLO_OUT | DONE)));
        tbl.push_back(v(0, 0, IR_ADD7, z));

        clr = 1'b1;
        run = 1'b0;
        ir  = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < tbl.size(); k++) begin
            cycle($sformatf("vec%0d", k), tbl[k].clr, tbl[k].run, tbl[k].ir, tbl[k].exp);
        end

        // halt: fetch, then halted held for 20 cycles regardless of run.
        cycle("halt_idle", 0, 1, IR_HALT, z);
        cycle("halt_t0", 0, 1, IR_HALT, f0);
        cycle("halt_t1", 0, 1, IR_HALT, f1);
        cycle("halt_t2", 0, 1, IR_HALT, f2);
        for (int k = 0; k < 20; k++) begin
            cycle($sformatf("halt_hold%0d", k), 0, 1, IR_HALT, o(5'h00, 16'h0, 16'h0, HALTED));
        end
        cycle("halt_clr", 1, 0, IR_HALT, o(5'h00, 16'h0, 16'h0, HALTED));
        cycle("halt_after_clr", 0, 0, IR_HALT, z);

        // clr during mul T5 returns to IDLE with every output low.
        cycle("mclr_idle", 0, 1, IR_MUL, z);
        cycle("mclr_t0", 0, 1, IR_MUL, f0);
        cycle("mclr_t1", 0, 1, IR_MUL, f1);
        cycle("mclr_t2", 0, 1, IR_MUL, f2);
        cycle("mclr_t3", 0, 1, IR_MUL, o(5'h00, 16'h0040, 16'h0, Y_EN));
        cycle("mclr_t4", 0, 1, IR_MUL, o(5'h0F, 16'h0004, 16'h0, ZLO_EN | ZHI_EN));
        cycle("mclr_t5", 1, 1, IR_MUL, o(5'h00, 16'h0, 16'h0, ZLO_OUT | LO_EN));
        cycle("mclr_after", 0, 0, IR_MUL, z);
        cycle("mclr_stay0", 0, 0, IR_MUL, z);
        cycle("mclr_stay1", 0, 0, IR_MUL, z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
